// File: rtl/range_weight_pipe.sv
// range_weight_pipe: two-stage range-kernel weight generator over a sliding window.
// Stage 1 registers the squared distance of every tap from the centre tap.
// Stage 2 maps each distance to a 4-bit weight.
// Ports:
//   clk, rst (async, active-high), clear (sync window flush)
//   in_valid/in_ready/in_data          : sample input handshake
//   out_valid/out_ready/weights/center : weight vector output handshake
// Optional macro RANGE_WSUM_EN adds output wsum, the registered sum of all weights.
module range_weight_pipe #(
    parameter int ORDER  = 7,
    parameter int DATA_W = 8,
    localparam int W_W   = 4,
    localparam int S_W   = 2 * DATA_W,
    localparam int CNT_W = $clog2(ORDER + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ORDER*W_W-1:0]   weights,
    output logic [DATA_W-1:0]      center
`ifdef RANGE_WSUM_EN
    ,
    output logic [W_W+CNT_W-1:0]   wsum
`endif
);

    localparam int C = ORDER / 2;

    // Inclusive upper bounds on S for weights 15 down to 1.
    localparam int unsigned BND [15] = '{
        8, 26, 46, 68, 91, 116, 145, 177,
        214, 256, 308, 372, 458, 589, 870
    };

    logic [DATA_W-1:0]    win   [ORDER];
    logic [DATA_W-1:0]    nwin  [ORDER];
    logic [S_W-1:0]       s1    [ORDER];
    logic [S_W-1:0]       s_nxt [ORDER];
    logic [DATA_W-1:0]    c1;
    logic                 v1;
    logic [CNT_W-1:0]     fill_cnt;
    logic                 advance;
    logic                 accept;
    logic                 full_next;
    logic [ORDER*W_W-1:0] w_nxt;

    assign advance   = !out_valid || out_ready;
    // Gated by rst so a held reset never advertises readiness.
    assign in_ready  = !rst && advance && !clear;
    assign accept    = in_valid && in_ready;
    assign full_next = (fill_cnt >= CNT_W'(ORDER - 1));

    function automatic logic [W_W-1:0] map_w(input logic [S_W-1:0] s);
        logic [31:0]    x;
        logic [W_W-1:0] w;
        x = 32'(s);
        w = '0;
        // Scan from the loosest bound so the tightest matching one wins.
        for (int i = 14; i >= 0; i--) begin
            if (x <= BND[i]) w = W_W'(15 - i);
        end
        return w;
    endfunction

    // Window as it will look after this cycle's accept; stage 1 works on it.
    always_comb begin
        nwin[0] = in_data;
        for (int k = 1; k < ORDER; k++) nwin[k] = win[k-1];
        for (int k = 0; k < ORDER; k++) begin
            logic [DATA_W-1:0] d;
            d = (nwin[k] >= nwin[C]) ? nwin[k] - nwin[C]
                                     : nwin[C] - nwin[k];
            s_nxt[k] = S_W'(d) * S_W'(d);
        end
    end

    always_comb begin
        w_nxt = '0;
        for (int k = 0; k < ORDER; k++) w_nxt[k*W_W +: W_W] = map_w(s1[k]);
    end

`ifdef RANGE_WSUM_EN
    logic [W_W+CNT_W-1:0] wsum_nxt;

    always_comb begin
        wsum_nxt = '0;
        for (int k = 0; k < ORDER; k++)
            wsum_nxt = wsum_nxt + (W_W+CNT_W)'(w_nxt[k*W_W +: W_W]);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) win[k] <= '0;
            fill_cnt <= '0;
        end else if (clear) begin
            for (int k = 0; k < ORDER; k++) win[k] <= '0;
            fill_cnt <= '0;
        end else if (accept) begin
            for (int k = 0; k < ORDER; k++) win[k] <= nwin[k];
            if (fill_cnt != CNT_W'(ORDER)) fill_cnt <= fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) s1[k] <= '0;
            c1 <= '0;
            v1 <= 1'b0;
        end else if (clear) begin
            v1 <= 1'b0;
        end else if (advance) begin
            v1 <= accept && full_next;
            if (accept) begin
                for (int k = 0; k < ORDER; k++) s1[k] <= s_nxt[k];
                c1 <= nwin[C];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            weights   <= '0;
            center    <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= v1;
            weights   <= w_nxt;
            center    <= c1;
        end
    end

`ifdef RANGE_WSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wsum <= '0;
        end else if (!clear && advance) begin
            wsum <= wsum_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_range_weight_pipe.sv
// tb_range_weight_pipe: scoreboard bench for range_weight_pipe (ORDER=7, DATA_W=8).
// Expected vectors are pushed on accept and compared when the DUT delivers.
module tb_range_weight_pipe;

    localparam int ORDER  = 7;
    localparam int DATA_W = 8;
    localparam int W_W    = 4;
    localparam int CNT_W  = 3;
    localparam int C      = ORDER / 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clear;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [ORDER*W_W-1:0] weights;
    logic [DATA_W-1:0]    center;
`ifdef RANGE_WSUM_EN
    logic [W_W+CNT_W-1:0] wsum;
`endif

    range_weight_pipe #(.ORDER(ORDER), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .weights   (weights),
        .center    (center)
`ifdef RANGE_WSUM_EN
        ,
        .wsum      (wsum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ORDER*W_W-1:0] w;
        logic [DATA_W-1:0]    c;
    } exp_t;

    exp_t q[$];
    int   mw [ORDER];
    int   mcnt;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   n_push = 0;
    logic [ORDER*W_W-1:0] last_w;
    logic [DATA_W-1:0]    last_c;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_w(input int s);
        int b [15] = '{8, 26, 46, 68, 91, 116, 145, 177,
                       214, 256, 308, 372, 458, 589, 870};
        for (int i = 0; i < 15; i++)
            if (s <= b[i]) return 4'(15 - i);
        return 4'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ORDER; k++) mw[k] = 0;
        mcnt = 0;
        q.delete();
    endtask

    task automatic model_accept(input int d);
        exp_t e;
        for (int k = ORDER - 1; k > 0; k--) mw[k] = mw[k-1];
        mw[0] = d;
        if (mcnt < ORDER) mcnt++;
        if (mcnt == ORDER) begin
            e.w = '0;
            for (int k = 0; k < ORDER; k++) begin
                int df;
                df = mw[k] - mw[C];
                if (df < 0) df = -df;
                e.w[k*W_W +: W_W] = ref_w(df * df);
            end
            e.c = DATA_W'(mw[C]);
            q.push_back(e);
            n_push++;
        end
    endtask

    task automatic step(input logic v, input int d, input logic ordy,
                        input logic clr);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_data   = d[DATA_W-1:0];
        out_ready = ordy;
        clear     = clr;
        #1;
        if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                chk("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                chk("weights", 64'(weights), 64'(e.w));
                chk("center", 64'(center), 64'(e.c));
`ifdef RANGE_WSUM_EN
                begin
                    int s;
                    s = 0;
                    for (int k = 0; k < ORDER; k++)
                        s += int'(e.w[k*W_W +: W_W]);
                    chk("wsum", 64'(wsum), 64'(s));
                end
`endif
                last_w = weights;
                last_c = center;
            end
        end
        if (in_valid && in_ready) model_accept(d);
        if (clr) model_reset();
    endtask

    task automatic feed7(input int a0, input int a1, input int a2,
                         input int a3, input int a4, input int a5,
                         input int a6);
        int s [7];
        s = '{a0, a1, a2, a3, a4, a5, a6};
        for (int i = 0; i < 7; i++) step(1'b1, s[i], 1'b1, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        int n0;
        int p0;
        logic [ORDER*W_W-1:0] hold_w;
        logic                 held;

        rst = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_weights", 64'(weights), 64'd0);
        chk("rst_center", 64'(center), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Flat window: all weights 15, latency check
        feed7(100, 100, 100, 100, 100, 100, 100);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("lat_edge1", 64'(out_valid), 64'd0);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("lat_edge2", 64'(out_valid), 64'd1);
        chk("flat_w", 64'(last_w), 64'hFFF_FFFF);
        chk("flat_c", 64'(last_c), 64'd100);
`ifdef RANGE_WSUM_EN
        chk("flat_wsum", 64'(wsum), 64'd105);
`endif
        drain(3);
        chk("q_empty1", 64'(q.size()), 64'd0);

        // Ramp
        step(1'b0, 0, 1'b1, 1'b1);
        feed7(0, 10, 20, 30, 40, 50, 60);
        drain(3);
        chk("ramp_w", 64'(last_w), 64'h03A_FA30);
        chk("ramp_c", 64'(last_c), 64'd30);

        // Threshold boundaries around C=50
        step(1'b0, 0, 1'b1, 1'b1);
        feed7(53, 48, 79, 50, 80, 20, 50);
        drain(3);
        chk("bound_w", 64'(last_w), 64'hEF1_F00F);

        // Extreme difference, no wrap
        step(1'b0, 0, 1'b1, 1'b1);
        feed7(255, 255, 255, 0, 255, 255, 255);
        drain(3);
        chk("extreme_w", 64'(last_w), 64'h000_F000);
        chk("extreme_c", 64'(last_c), 64'd0);

        // Streaming with a stall
        step(1'b0, 0, 1'b1, 1'b1);
        n0 = n_out;
        p0 = n_push;
        for (int i = 0; i < 9; i++)
            step(1'b1, int'($urandom_range(0, 255)), 1'b1, 1'b0);
        held = 1'b0;
        hold_w = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, int'($urandom_range(0, 255)), 1'b0, 1'b0);
            if (out_valid) begin
                if (!held) begin
                    hold_w = weights;
                    held = 1'b1;
                end else begin
                    chk("stall_hold", 64'(weights), 64'(hold_w));
                end
                chk("stall_ready", 64'(in_ready), 64'd0);
            end
        end
        chk("stall_seen", 64'(held), 64'd1);
        drain(5);
        chk("stall_count", 64'(n_out - n0), 64'(n_push - p0));
        chk("q_empty2", 64'(q.size()), 64'd0);

        // Clear after the 4th sample
        step(1'b0, 0, 1'b1, 1'b1);
        n0 = n_out;
        for (int i = 0; i < 4; i++) step(1'b1, 10 * i, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 7 * i, 1'b1, 1'b0);
        drain(3);
        chk("clr_noout", 64'(n_out - n0), 64'd0);
        step(1'b1, 200, 1'b1, 1'b0);
        drain(3);
        chk("clr_out", 64'(n_out - n0), 64'd1);

        // Reset in the middle of a stall
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 20 + i, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_w", 64'(weights), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_rst_ready", 64'(in_ready), 64'd1);
        n0 = n_out;
        for (int i = 0; i < 6; i++) step(1'b1, 90, 1'b1, 1'b0);
        drain(3);
        chk("rst_partial", 64'(n_out - n0), 64'd0);
        step(1'b1, 60, 1'b1, 1'b0);
        drain(3);
        chk("rst_refill", 64'(n_out - n0), 64'd1);
        chk("q_empty3", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
